// File: rtl/axi_write_arbiter_pkg.sv
// Shared state encodings and channel indices for the 2->1 AXI3 write arbiter.
package axi_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/axi_write_arbiter.sv
// 2->1 AXI3 write-path arbiter: one transaction at a time, grant held from AW through B,
// fixed priority to ch0 with a starvation guard that forces ch1 after STARVE_LIMIT ch0 wins.
module axi_write_arbiter
  import axi_write_arbiter_pkg::*;
#(
  parameter int ID_W         = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int STRB_W      = DATA_W / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2*ID_W-1:0]     s_axi_awid,
  input  logic [2*ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [5:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awvalid,
  output logic [1:0]            s_axi_awready,
  input  logic [2*ID_W-1:0]     s_axi_wid,
  input  logic [2*DATA_W-1:0]   s_axi_wdata,
  input  logic [2*STRB_W-1:0]   s_axi_wstrb,
  input  logic [1:0]            s_axi_wlast,
  input  logic [1:0]            s_axi_wvalid,
  output logic [1:0]            s_axi_wready,
  output logic [3:0]            s_axi_bresp,
  output logic [1:0]            s_axi_bvalid,
  input  logic [1:0]            s_axi_bready,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [3:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ID_W-1:0]       m_axi_wid,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [STRB_W-1:0]     m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  wlast_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_e       r_state, w_state_next;
  logic             r_grant, w_grant_next;
  logic [3:0]       r_beat_cnt, w_beat_next;
  logic [SC_W-1:0]  r_starve_cnt, w_starve_next;
  logic             r_wlast_err, w_err_next;
  logic             w_arb_grant;

  logic [ID_W-1:0]   w_awid   [2];
  logic [ADDR_W-1:0] w_awaddr [2];
  logic [3:0]        w_awlen  [2];
  logic [2:0]        w_awsize [2];
  logic [ID_W-1:0]   w_wid    [2];
  logic [DATA_W-1:0] w_wdata  [2];
  logic [STRB_W-1:0] w_wstrb  [2];

  // Unpack the {ch1,ch0} concatenated buses into per-channel views.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign w_awid[gi]   = s_axi_awid[gi*ID_W +: ID_W];
    assign w_awaddr[gi] = s_axi_awaddr[gi*ADDR_W +: ADDR_W];
    assign w_awlen[gi]  = s_axi_awlen[gi*4 +: 4];
    assign w_awsize[gi] = s_axi_awsize[gi*3 +: 3];
    assign w_wid[gi]    = s_axi_wid[gi*ID_W +: ID_W];
    assign w_wdata[gi]  = s_axi_wdata[gi*DATA_W +: DATA_W];
    assign w_wstrb[gi]  = s_axi_wstrb[gi*STRB_W +: STRB_W];
  end

  assign m_axi_awid   = w_awid[r_grant];
  assign m_axi_awaddr = w_awaddr[r_grant];
  assign m_axi_awlen  = w_awlen[r_grant];
  assign m_axi_awsize = w_awsize[r_grant];
  assign m_axi_wid    = w_wid[r_grant];
  assign m_axi_wdata  = w_wdata[r_grant];
  assign m_axi_wstrb  = w_wstrb[r_grant];
  assign m_axi_wlast  = s_axi_wlast[r_grant];
  assign wlast_err    = r_wlast_err;

  // ch1 wins when alone or once ch0 has won STARVE_LIMIT times in a row while ch1 waited.
  assign w_arb_grant = s_axi_awvalid[CH1] &
                       (~s_axi_awvalid[CH0] | (r_starve_cnt == STARVE_MAX));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant      <= CH0;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
      r_wlast_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_beat_cnt   <= w_beat_next;
      r_starve_cnt <= w_starve_next;
      r_wlast_err  <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_beat_next   = r_beat_cnt;
    w_starve_next = r_starve_cnt;
    w_err_next    = r_wlast_err;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_axi_awready = 2'b00;
    s_axi_wready  = 2'b00;
    s_axi_bvalid  = 2'b00;
    s_axi_bresp   = 4'b0000;
    unique case (r_state)
      IDLE: begin
        if (|s_axi_awvalid) begin
          w_state_next = ADDR;
          w_grant_next = w_arb_grant;
          if (w_arb_grant == CH1 || !s_axi_awvalid[CH1]) begin
            w_starve_next = '0;
          end else if (r_starve_cnt != STARVE_MAX) begin
            w_starve_next = r_starve_cnt + 1'b1;
          end
        end
      end
      ADDR: begin
        m_axi_awvalid          = s_axi_awvalid[r_grant];
        s_axi_awready[r_grant] = m_axi_awready;
        if (s_axi_awvalid[r_grant] && m_axi_awready) begin
          w_beat_next  = w_awlen[r_grant];
          w_state_next = DATA;
        end
      end
      DATA: begin
        m_axi_wvalid          = s_axi_wvalid[r_grant];
        s_axi_wready[r_grant] = m_axi_wready;
        if (s_axi_wvalid[r_grant] && m_axi_wready) begin
          w_beat_next = r_beat_cnt - 1'b1;
          // Flag the mismatch but let wlast decide when the burst ends.
          if (s_axi_wlast[r_grant] != (r_beat_cnt == 4'd0)) begin
            w_err_next = 1'b1;
          end
          if (s_axi_wlast[r_grant]) begin
            w_state_next = RESP;
          end
        end
      end
      RESP: begin
        s_axi_bvalid[r_grant] = m_axi_bvalid;
        if (r_grant == CH1) begin
          s_axi_bresp[3:2] = m_axi_bresp;
        end else begin
          s_axi_bresp[1:0] = m_axi_bresp;
        end
        m_axi_bready = s_axi_bready[r_grant];
        if (m_axi_bvalid && s_axi_bready[r_grant]) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: per-channel requester drivers, a responding
// slave model and a monitor that checks every AW/W/B handshake against queued expectations.
module tb_axi_write_arbiter;
  import axi_write_arbiter_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int BUDGET = 400;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    int                nbeats;
    logic [DATA_W-1:0] base;
    logic [STRB_W-1:0] strb;
  } cmd_t;
  typedef struct {
    int ch; logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; logic [3:0] len; logic [2:0] size;
  } aw_exp_t;
  typedef struct {
    int ch; logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; logic last;
  } w_exp_t;
  typedef struct {
    int ch; logic [1:0] resp;
  } b_exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  wire  logic [2*ID_W-1:0]   s_axi_awid;
  wire  logic [2*ADDR_W-1:0] s_axi_awaddr;
  wire  logic [7:0]          s_axi_awlen;
  wire  logic [5:0]          s_axi_awsize;
  wire  logic [1:0]          s_axi_awvalid;
  logic [1:0]                s_axi_awready;
  wire  logic [2*ID_W-1:0]   s_axi_wid;
  wire  logic [2*DATA_W-1:0] s_axi_wdata;
  wire  logic [2*STRB_W-1:0] s_axi_wstrb;
  wire  logic [1:0]          s_axi_wlast;
  wire  logic [1:0]          s_axi_wvalid;
  logic [1:0]                s_axi_wready;
  logic [3:0]                s_axi_bresp;
  logic [1:0]                s_axi_bvalid;
  wire  logic [1:0]          s_axi_bready;
  logic [ID_W-1:0]           m_axi_awid;
  logic [ADDR_W-1:0]         m_axi_awaddr;
  logic [3:0]                m_axi_awlen;
  logic [2:0]                m_axi_awsize;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;
  logic [ID_W-1:0]           m_axi_wid;
  logic [DATA_W-1:0]         m_axi_wdata;
  logic [STRB_W-1:0]         m_axi_wstrb;
  logic                      m_axi_wlast;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;
  logic                      wlast_err;

  aw_exp_t exp_aw_q[$];
  w_exp_t  exp_w_q[$];
  b_exp_t  exp_b_q[$];
  int      n_checks = 0;
  int      n_fail = 0;
  int      w_hs_total = 0;
  bit      bp = 1'b0;
  bit      abort = 1'b0;

  axi_write_arbiter #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wlast_err(wlast_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int ch);
    return (ch == 1) ? 2'b10 : 2'b01;
  endfunction

  // Requester drivers: AW and W are offered together, so a waiting channel's W beats
  // sit on the bus early and must be stalled by the arbiter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    cmd_t              cmd_q[$];
    logic              awvalid = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [3:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic              wvalid = 1'b0;
    logic [ID_W-1:0]   wid = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [STRB_W-1:0] wstrb = '0;
    logic              wlast = 1'b0;
    logic              bready = 1'b0;
    bit                busy = 1'b0;

    initial begin : drv
      cmd_t c;
      int   n;
      bit   got;
      forever begin
        if (cmd_q.size() == 0 || abort) begin
          @(posedge aclk); #1;
          continue;
        end
        c = cmd_q.pop_front();
        busy = 1'b1;
        awid = c.id; awaddr = c.addr; awlen = c.len; awsize = 3'd2; awvalid = 1'b1;
        wid = c.id;
        fork
          begin : aw_ph
            int  an;
            bit  ag;
            an = 0;
            while (1) begin
              @(negedge aclk); ag = s_axi_awready[gi];
              @(posedge aclk); #1;
              if (ag || abort) break;
              an++;
              if (an > BUDGET) begin chk("aw_timeout", 64'(an), 64'(0)); break; end
            end
            awvalid = 1'b0;
          end
          begin : w_ph
            int  wn;
            bit  wg;
            for (int b = 0; b < c.nbeats; b++) begin
              wdata  = c.base + DATA_W'(b);
              wstrb  = b[0] ? ~c.strb : c.strb;
              wlast  = (b == c.nbeats - 1);
              wvalid = 1'b1;
              wn = 0;
              while (1) begin
                @(negedge aclk); wg = s_axi_wready[gi];
                @(posedge aclk); #1;
                if (wg || abort) break;
                wn++;
                if (wn > BUDGET) begin chk("w_timeout", 64'(wn), 64'(0)); break; end
              end
              if (abort) break;
            end
            wvalid = 1'b0;
            wlast  = 1'b0;
          end
        join
        n = 0;
        while (!abort) begin
          bready = bp ? ~bready : 1'b1;
          @(negedge aclk); got = s_axi_bvalid[gi] & bready;
          @(posedge aclk); #1;
          if (got) break;
          n++;
          if (n > BUDGET) begin chk("b_timeout", 64'(n), 64'(0)); break; end
        end
        bready = 1'b0;
        busy = 1'b0;
      end
    end
  end

  assign s_axi_awvalid = {g_req[1].awvalid, g_req[0].awvalid};
  assign s_axi_awid    = {g_req[1].awid, g_req[0].awid};
  assign s_axi_awaddr  = {g_req[1].awaddr, g_req[0].awaddr};
  assign s_axi_awlen   = {g_req[1].awlen, g_req[0].awlen};
  assign s_axi_awsize  = {g_req[1].awsize, g_req[0].awsize};
  assign s_axi_wvalid  = {g_req[1].wvalid, g_req[0].wvalid};
  assign s_axi_wid     = {g_req[1].wid, g_req[0].wid};
  assign s_axi_wdata   = {g_req[1].wdata, g_req[0].wdata};
  assign s_axi_wstrb   = {g_req[1].wstrb, g_req[0].wstrb};
  assign s_axi_wlast   = {g_req[1].wlast, g_req[0].wlast};
  assign s_axi_bready  = {g_req[1].bready, g_req[0].bready};

  // Slave model (answers B with awaddr[5:4] as bresp) plus the scoreboard monitor.
  initial begin : slave_mon
    logic       tog;
    bit         b_pend, aw_hs, w_hs, w_last, mb_hs;
    logic [1:0] b_resp, sb_hs, act_grant;
    aw_exp_t    ea;
    w_exp_t     ew;
    b_exp_t     eb;
    tog = 1'b0; b_pend = 1'b0; b_resp = 2'b00;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge aclk);
      aw_hs  = m_axi_awvalid && m_axi_awready;
      w_hs   = m_axi_wvalid && m_axi_wready;
      w_last = m_axi_wlast;
      mb_hs  = m_axi_bvalid && m_axi_bready;
      sb_hs  = s_axi_bvalid & s_axi_bready;
      act_grant = s_axi_awready | s_axi_wready | s_axi_bvalid;
      if (aresetn) begin
        if (|act_grant) chk("single_grant", 64'(act_grant == 2'b11), 64'(0));
        if (aw_hs) begin
          b_resp = m_axi_awaddr[5:4];
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
          else begin
            ea = exp_aw_q.pop_front();
            chk("aw_grant", 64'(s_axi_awready), 64'(onehot(ea.ch)));
            chk("aw_id", 64'(m_axi_awid), 64'(ea.id));
            chk("aw_addr", 64'(m_axi_awaddr), 64'(ea.addr));
            chk("aw_len", 64'(m_axi_awlen), 64'(ea.len));
            chk("aw_size", 64'(m_axi_awsize), 64'(ea.size));
          end
        end
        if (w_hs) begin
          w_hs_total++;
          if (exp_w_q.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
          else begin
            ew = exp_w_q.pop_front();
            chk("w_grant", 64'(s_axi_wready), 64'(onehot(ew.ch)));
            chk("w_id", 64'(m_axi_wid), 64'(ew.id));
            chk("w_data", 64'(m_axi_wdata), 64'(ew.data));
            chk("w_strb", 64'(m_axi_wstrb), 64'(ew.strb));
            chk("w_last", 64'(w_last), 64'(ew.last));
          end
        end
        if (mb_hs || (|sb_hs)) chk("b_pass", 64'(mb_hs), 64'(|sb_hs));
        if (|sb_hs) begin
          if (exp_b_q.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
          else begin
            eb = exp_b_q.pop_front();
            chk("b_valid", 64'(s_axi_bvalid), 64'(onehot(eb.ch)));
            chk("b_resp", 64'(s_axi_bresp), 64'(eb.ch == 1 ? {eb.resp, 2'b00} : {2'b00, eb.resp}));
            $display("txn done: ch%0d bresp=%0d bvalid=%b", eb.ch, eb.resp, s_axi_bvalid);
          end
        end
      end
      @(posedge aclk); #1;
      if (!aresetn) b_pend = 1'b0;
      else begin
        if (w_hs && w_last) b_pend = 1'b1;
        if (mb_hs) b_pend = 1'b0;
      end
      tog = ~tog;
      m_axi_awready = bp ? tog : 1'b1;
      m_axi_wready  = bp ? tog : 1'b1;
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = b_pend ? b_resp : 2'b00;
    end
  end

  task automatic issue(input int ch, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [3:0] len, input int nbeats, input logic [DATA_W-1:0] base,
                       input logic [STRB_W-1:0] strb, input logic [1:0] resp);
    cmd_t    c;
    aw_exp_t a;
    w_exp_t  w;
    b_exp_t  b;
    c.id = id; c.addr = addr; c.len = len; c.nbeats = nbeats; c.base = base; c.strb = strb;
    a.ch = ch; a.id = id; a.addr = addr; a.len = len; a.size = 3'd2;
    exp_aw_q.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      w.ch = ch; w.id = id; w.data = base + DATA_W'(i);
      w.strb = (i % 2 == 1) ? ~strb : strb;
      w.last = (i == nbeats - 1);
      exp_w_q.push_back(w);
    end
    b.ch = ch; b.resp = resp;
    exp_b_q.push_back(b);
    if (ch == 0) g_req[0].cmd_q.push_back(c);
    else         g_req[1].cmd_q.push_back(c);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0 ||
            g_req[0].cmd_q.size() + g_req[1].cmd_q.size() != 0 ||
            g_req[0].busy || g_req[1].busy) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    chk({nm, "_drain_timeout"}, 64'(n >= 3000), 64'(0));
    @(posedge aclk); #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_m_awvalid"}, 64'(m_axi_awvalid), 64'(0));
    chk({nm, "_m_wvalid"}, 64'(m_axi_wvalid), 64'(0));
    chk({nm, "_m_bready"}, 64'(m_axi_bready), 64'(0));
    chk({nm, "_s_awready"}, 64'(s_axi_awready), 64'(0));
    chk({nm, "_s_wready"}, 64'(s_axi_wready), 64'(0));
    chk({nm, "_s_bvalid"}, 64'(s_axi_bvalid), 64'(0));
  endtask

  logic [1:0] starve_resp [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

  initial begin : main
    int wtot, n;
    repeat (3) @(posedge aclk);
    #2;
    chk_quiet("in_reset");
    chk("rst_wlast_err", 64'(wlast_err), 64'(0));
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    chk_quiet("idle");

    issue(0, 4'h3, 32'h1FC0_0000, 4'd3, 4, 32'hA000_0000, 4'hF, 2'b00);
    drain("single");
    chk("single_wlast_err", 64'(wlast_err), 64'(0));

    issue(0, 4'h1, 32'h1000_0010, 4'd1, 2, 32'hB000_0000, 4'h3, 2'b01);
    issue(1, 4'h8, 32'h2000_0020, 4'd2, 3, 32'hB100_0000, 4'hE, 2'b10);
    drain("simul");

    for (int k = 0; k < 7; k++) begin
      issue((k == 4) ? 1 : 0, 4'(k), 32'h0000_1000 + 32'(k * 16), 4'd1, 2,
            32'hC0DE_0000 + 32'(k << 8), 4'h9, starve_resp[k]);
    end
    drain("starve");

    bp = 1'b1;
    issue(0, 4'h5, 32'h3000_0030, 4'd3, 4, 32'h1122_3340, 4'b0101, 2'b11);
    issue(1, 4'h9, 32'h4000_0000, 4'd2, 3, 32'h5566_7780, 4'b1100, 2'b00);
    drain("backpressure");
    bp = 1'b0;
    chk("bp_wlast_err", 64'(wlast_err), 64'(0));

    issue(1, 4'h2, 32'h5000_0010, 4'd1, 1, 32'hDEAD_0000, 4'hF, 2'b01);
    drain("proto_err");
    chk("proto_wlast_err", 64'(wlast_err), 64'(1));
    issue(0, 4'h4, 32'h6000_0000, 4'd0, 1, 32'hBEEF_0000, 4'hF, 2'b00);
    drain("sticky");
    chk("sticky_wlast_err", 64'(wlast_err), 64'(1));

    wtot = w_hs_total;
    issue(0, 4'h7, 32'h7000_0000, 4'd3, 4, 32'h0F0F_0000, 4'hF, 2'b00);
    n = 0;
    while (w_hs_total < wtot + 2 && n < BUDGET) begin @(posedge aclk); n++; end
    chk("mid_reset_wait", 64'(n >= BUDGET), 64'(0));
    @(posedge aclk); #2;
    abort = 1'b1;
    aresetn = 1'b0;
    #1;
    chk_quiet("mid_reset");
    chk("mid_reset_state", 64'(dut.r_state), 64'(IDLE));
    chk("mid_reset_wlast_err", 64'(wlast_err), 64'(0));
    exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    abort = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_quiet("post_reset_idle");

    issue(1, 4'hC, 32'h0800_0020, 4'd2, 3, 32'h7777_0000, 4'h6, 2'b10);
    drain("post_reset");
    chk("post_reset_wlast_err", 64'(wlast_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
